// File: rtl/address_generator_if.sv
// Control/strobe bundle between a sample-rate controller and the address generator.
// master drives configuration and frequency loads; slave returns read strobes and addresses.
interface address_generator_if #(
  parameter int unsigned ACC_W = 24,
  parameter int unsigned DIV_W = 16,
  parameter int unsigned AW    = 5
);
  logic             enable;
  logic [DIV_W-1:0] div;
  logic [ACC_W-1:0] freq_word;
  logic             freq_load;
  logic             freq_busy;
  logic             read;
  logic [AW-1:0]    address;
  logic             wrap;

  modport master (
    output enable, div, freq_word, freq_load,
    input  freq_busy, read, address, wrap
  );

  modport slave (
    input  enable, div, freq_word, freq_load,
    output freq_busy, read, address, wrap
  );
endinterface

// File: rtl/address_generator.sv
// DDS-style waveform table address generator: prescaled phase accumulator with pending/active frequency words.
// Define ADDR_GEN_WRAP_SYNC_EN to defer frequency changes to start edges and accumulator wraps.
module address_generator #(
  parameter int unsigned N     = 32,
  parameter int unsigned ACC_W = 24,
  parameter int unsigned DIV_W = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  address_generator_if.slave  bus_if
);

  function automatic int unsigned clogb2(input int unsigned value);
    int unsigned r;
    int unsigned x;
    r = 0;
    x = value - 1;
    while (x > 0) begin
      r = r + 1;
      x = x >> 1;
    end
    return r;
  endfunction

  localparam int unsigned AW = clogb2(N);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t           r_state,   w_state_nxt;
  logic [ACC_W-1:0] r_phase,   w_phase_nxt;
  logic [DIV_W-1:0] r_presc,   w_presc_nxt;
  logic [ACC_W-1:0] r_active,  w_active_nxt;
  logic [ACC_W-1:0] r_pending, w_pending_nxt;
  logic             r_busy,    w_busy_nxt;
  logic             r_read,    w_read_nxt;
  logic [AW-1:0]    r_addr,    w_addr_nxt;
  logic             r_wrap,    w_wrap_nxt;
  logic [ACC_W:0]   w_sum;
  logic             w_apply;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_phase   <= '0;
      r_presc   <= '0;
      r_active  <= '0;
      r_pending <= '0;
      r_busy    <= 1'b0;
      r_read    <= 1'b0;
      r_addr    <= '0;
      r_wrap    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_phase   <= w_phase_nxt;
      r_presc   <= w_presc_nxt;
      r_active  <= w_active_nxt;
      r_pending <= w_pending_nxt;
      r_busy    <= w_busy_nxt;
      r_read    <= w_read_nxt;
      r_addr    <= w_addr_nxt;
      r_wrap    <= w_wrap_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_phase_nxt   = r_phase;
    w_presc_nxt   = r_presc;
    w_active_nxt  = r_active;
    w_pending_nxt = r_pending;
    w_busy_nxt    = r_busy;
    w_read_nxt    = 1'b0;
    w_wrap_nxt    = 1'b0;
    w_addr_nxt    = r_addr;
    w_apply       = 1'b0;
    w_sum         = {1'b0, r_phase} + {1'b0, r_active};

    case (r_state)
      S_IDLE: begin
        if (bus_if.enable) begin
          w_state_nxt = S_RUN;
          w_phase_nxt = '0;
          w_presc_nxt = '0;
          w_read_nxt  = 1'b1;
          w_addr_nxt  = '0;
          w_wrap_nxt  = 1'b1;
          w_apply     = 1'b1;
        end
      end
      S_RUN: begin
        if (!bus_if.enable) begin
          w_state_nxt = S_IDLE;
        end else if (r_presc == bus_if.div) begin
          // Tick: advance with the active word as it stood before this edge
          w_presc_nxt = '0;
          w_phase_nxt = w_sum[ACC_W-1:0];
          w_read_nxt  = 1'b1;
          w_addr_nxt  = w_sum[ACC_W-1 -: AW];
          w_wrap_nxt  = w_sum[ACC_W];
`ifdef ADDR_GEN_WRAP_SYNC_EN
          w_apply     = w_sum[ACC_W];
`else
          w_apply     = 1'b1;
`endif
        end else begin
          // Free-running count; a div lowered below the count wraps through all-ones
          w_presc_nxt = r_presc + DIV_W'(1);
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase

    if (w_apply && r_busy) begin
      w_active_nxt = r_pending;
      w_busy_nxt   = 1'b0;
    end

    // A load on the apply edge refills pending after the old value moved to active
    if (bus_if.freq_load) begin
      w_pending_nxt = bus_if.freq_word;
      w_busy_nxt    = 1'b1;
    end
  end

  assign bus_if.freq_busy = r_busy;
  assign bus_if.read      = r_read;
  assign bus_if.address   = r_addr;
  assign bus_if.wrap      = r_wrap;

endmodule

// File: tb/tb_address_generator.sv
// Directed, table-driven bench for address_generator (N=32, ACC_W=16, DIV_W=8).
// Expectations for frequency-change timing follow ADDR_GEN_WRAP_SYNC_EN.
module tb_address_generator;

  localparam int unsigned ACC_W = 16;
  localparam int unsigned DIV_W = 8;
  localparam int unsigned AW    = 5;

  logic clk;
  logic rst_n;

  address_generator_if #(.ACC_W(ACC_W), .DIV_W(DIV_W), .AW(AW)) bus_if ();

  address_generator #(.N(32), .ACC_W(ACC_W), .DIV_W(DIV_W)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .bus_if (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic             en;
    logic [DIV_W-1:0] div;
    logic [ACC_W-1:0] fw;
    logic             ld;
    logic             rd;
    logic [AW-1:0]    addr;
    logic             wr;
    logic             busy;
  } vec_t;

  localparam int NVEC = 24;
  vec_t tbl [NVEC];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus_if.enable    = 1'b0;
    bus_if.div       = '0;
    bus_if.freq_word = '0;
    bus_if.freq_load = 1'b0;
    #3;
    chk("rst_read", 32'(bus_if.read), 32'd0);
    chk("rst_addr", 32'(bus_if.address), 32'd0);
    chk("rst_wrap", 32'(bus_if.wrap), 32'd0);
    chk("rst_busy", 32'(bus_if.freq_busy), 32'd0);
    step();
    rst_n = 1'b1;
  endtask

  // nlow idle cycles with read low, then one tick with the given outputs
  task automatic tick_expect(input int nlow, input logic [AW-1:0] a, input logic w, input logic b);
    for (int i = 0; i < nlow; i++) begin
      step();
      chk("idle_read", 32'(bus_if.read), 32'd0);
    end
    step();
    chk("tick_read", 32'(bus_if.read), 32'd1);
    chk("tick_addr", 32'(bus_if.address), 32'(a));
    chk("tick_wrap", 32'(bus_if.wrap), 32'(w));
    chk("tick_busy", 32'(bus_if.freq_busy), 32'(b));
  endtask

  task automatic set_vec(input int i, input logic en, input logic [DIV_W-1:0] dv,
                         input logic [ACC_W-1:0] fw, input logic ld, input logic rd,
                         input logic [AW-1:0] a, input logic wr, input logic b);
    tbl[i].en = en; tbl[i].div = dv; tbl[i].fw = fw; tbl[i].ld = ld;
    tbl[i].rd = rd; tbl[i].addr = a; tbl[i].wr = wr; tbl[i].busy = b;
  endtask

  initial begin
    int cnt;
    logic [AW-1:0] e1;
    rst_n = 1'b0;

    // div=0, step 0x1000: a read every cycle, addresses advance by 2, wrap every 16th read
    set_vec(0, 1'b0, 8'd0, 16'h1000, 1'b1, 1'b0, 5'd0, 1'b0, 1'b1);
    set_vec(1, 1'b1, 8'd0, 16'h0000, 1'b0, 1'b1, 5'd0, 1'b1, 1'b0);
    for (int k = 1; k <= 15; k++)
      set_vec(k + 1, 1'b1, 8'd0, 16'h0000, 1'b0, 1'b1, 5'(2 * k), 1'b0, 1'b0);
    set_vec(17, 1'b1, 8'd0, 16'h0000, 1'b0, 1'b1, 5'd0, 1'b1, 1'b0);
    set_vec(18, 1'b1, 8'd0, 16'h0000, 1'b0, 1'b1, 5'd2, 1'b0, 1'b0);
    set_vec(19, 1'b0, 8'd0, 16'h0000, 1'b0, 1'b0, 5'd2, 1'b0, 1'b0);
    set_vec(20, 1'b0, 8'd0, 16'h0000, 1'b1, 1'b0, 5'd2, 1'b0, 1'b1);
    set_vec(21, 1'b1, 8'd0, 16'h0000, 1'b0, 1'b1, 5'd0, 1'b1, 1'b0);
    set_vec(22, 1'b1, 8'd0, 16'h0000, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0);
    set_vec(23, 1'b1, 8'd0, 16'h0000, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0);

    do_reset();
    for (int i = 0; i < NVEC; i++) begin
      bus_if.enable    = tbl[i].en;
      bus_if.div       = tbl[i].div;
      bus_if.freq_word = tbl[i].fw;
      bus_if.freq_load = tbl[i].ld;
      step();
      chk($sformatf("vec%0d_read", i), 32'(bus_if.read), 32'(tbl[i].rd));
      chk($sformatf("vec%0d_addr", i), 32'(bus_if.address), 32'(tbl[i].addr));
      chk($sformatf("vec%0d_wrap", i), 32'(bus_if.wrap), 32'(tbl[i].wr));
      chk($sformatf("vec%0d_busy", i), 32'(bus_if.freq_busy), 32'(tbl[i].busy));
    end

    // div=3, step 0x0800: one read every 4 cycles, full table sweep then wrap
    do_reset();
    bus_if.div       = 8'd3;
    bus_if.freq_word = 16'h0800;
    bus_if.freq_load = 1'b1;
    step();
    chk("load_busy", 32'(bus_if.freq_busy), 32'd1);
    chk("load_read", 32'(bus_if.read), 32'd0);
    bus_if.freq_load = 1'b0;
    bus_if.enable    = 1'b1;
    step();
    chk("start_read", 32'(bus_if.read), 32'd1);
    chk("start_addr", 32'(bus_if.address), 32'd0);
    chk("start_wrap", 32'(bus_if.wrap), 32'd1);
    chk("start_busy", 32'(bus_if.freq_busy), 32'd0);
    for (int k = 1; k <= 32; k++)
      tick_expect(3, 5'(k % 32), (k == 32), 1'b0);
    for (int k = 1; k <= 5; k++)
      tick_expect(3, 5'(k), 1'b0, 1'b0);

    // Frequency change to 0x1000 requested right after the read of address 5
    bus_if.freq_word = 16'h1000;
    bus_if.freq_load = 1'b1;
    step();
    bus_if.freq_load = 1'b0;
    chk("chg_busy", 32'(bus_if.freq_busy), 32'd1);
    chk("chg_read", 32'(bus_if.read), 32'd0);
`ifdef ADDR_GEN_WRAP_SYNC_EN
    tick_expect(2, 5'd6, 1'b0, 1'b1);
    for (int a = 7; a <= 31; a++)
      tick_expect(3, 5'(a), 1'b0, 1'b1);
    tick_expect(3, 5'd0, 1'b1, 1'b0);
    tick_expect(3, 5'd2, 1'b0, 1'b0);
    tick_expect(3, 5'd4, 1'b0, 1'b0);
    e1 = 5'd6;
`else
    tick_expect(2, 5'd6, 1'b0, 1'b0);
    tick_expect(3, 5'd8, 1'b0, 1'b0);
    tick_expect(3, 5'd10, 1'b0, 1'b0);
    e1 = 5'd12;
`endif

    // Lower div beneath the running prescaler: it must wrap through 255 before ticking
    step();
    step();
    bus_if.div = 8'd1;
    cnt = 0;
    do begin
      step();
      cnt++;
    end while (bus_if.read !== 1'b1 && cnt < 400);
    chk("divdrop_cycles", 32'(cnt), 32'd256);
    chk("divdrop_addr", 32'(bus_if.address), 32'(e1));
    tick_expect(1, e1 + 5'd2, 1'b0, 1'b0);

    // Stop at address 7, hold, then restart from zero
    do_reset();
    bus_if.freq_word = 16'h0800;
    bus_if.freq_load = 1'b1;
    step();
    bus_if.freq_load = 1'b0;
    bus_if.enable    = 1'b1;
    tick_expect(0, 5'd0, 1'b1, 1'b0);
    for (int k = 1; k <= 7; k++)
      tick_expect(0, 5'(k), 1'b0, 1'b0);
    bus_if.enable = 1'b0;
    step();
    chk("stop_read", 32'(bus_if.read), 32'd0);
    chk("stop_addr", 32'(bus_if.address), 32'd7);
    chk("stop_wrap", 32'(bus_if.wrap), 32'd0);
    step();
    chk("hold_read", 32'(bus_if.read), 32'd0);
    chk("hold_addr", 32'(bus_if.address), 32'd7);
    bus_if.enable = 1'b1;
    tick_expect(0, 5'd0, 1'b1, 1'b0);
    tick_expect(0, 5'd1, 1'b0, 1'b0);

    // Load lands on a tick with nothing pending: stored only, outputs all nonzero
    bus_if.freq_word = 16'h1000;
    bus_if.freq_load = 1'b1;
    step();
    bus_if.freq_load = 1'b0;
    chk("pre_rst_read", 32'(bus_if.read), 32'd1);
    chk("pre_rst_addr", 32'(bus_if.address), 32'd2);
    chk("pre_rst_busy", 32'(bus_if.freq_busy), 32'd1);

    // Asynchronous reset between edges
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_read", 32'(bus_if.read), 32'd0);
    chk("async_addr", 32'(bus_if.address), 32'd0);
    chk("async_wrap", 32'(bus_if.wrap), 32'd0);
    chk("async_busy", 32'(bus_if.freq_busy), 32'd0);
    bus_if.enable = 1'b0;
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("post_rst_read", 32'(bus_if.read), 32'd0);
      chk("post_rst_busy", 32'(bus_if.freq_busy), 32'd0);
    end
    bus_if.enable = 1'b1;
    tick_expect(0, 5'd0, 1'b1, 1'b0);
    // Pending word was dropped by reset, so the active step stays zero
    tick_expect(0, 5'd0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
